// File: rtl/ysyx_24080014_mem_responder.sv
// Memory-side responder: latched request, configurable latency, byte-masked word storage.
// Define MEM_RESP_LFSR_DELAY_EN to add 0..3 pseudo-random extra cycles of latency per request.
module ysyx_24080014_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        ren,
    input  logic        wen,
    input  logic [7:0]  wmask,
    input  logic [31:0] raddr,
    input  logic [31:0] waddr,
    input  logic [31:0] din,
    output logic        mem_ready,
    output logic [31:0] dout,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY + 3) + 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_load;

    logic          ren_q, wen_q;
    logic [3:0]    wmask_q;
    logic [31:0]   raddr_q, waddr_q, din_q;

    logic [31:0]   dout_q, dout_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];

    logic          unused_wmask;
    assign unused_wmask = ^wmask[7:4];

`ifdef MEM_RESP_LFSR_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign cnt_load = CW'(LATENCY - 1) + CW'(lfsr_q[1:0]);
`else
    assign cnt_load = CW'(LATENCY - 1);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (valid) begin
                    cnt_d   = cnt_load;
                    state_d = (cnt_load == '0) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A zero-wait accept commits on the same edge, so operands come straight from the inputs.
    logic        commit, from_idle;
    logic        c_ren, c_wen, c_err;
    logic [3:0]  c_wmask;
    logic [31:0] c_raddr, c_waddr, c_din;

    assign commit    = (state_d == StResp) && (state_q != StResp);
    assign from_idle = (state_q == StIdle);
    assign c_ren     = from_idle ? ren        : ren_q;
    assign c_wen     = from_idle ? wen        : wen_q;
    assign c_wmask   = from_idle ? wmask[3:0] : wmask_q;
    assign c_raddr   = from_idle ? raddr      : raddr_q;
    assign c_waddr   = from_idle ? waddr      : waddr_q;
    assign c_din     = from_idle ? din        : din_q;

    logic        r_oob, w_oob, we;
    logic [31:0] rword, rdata, wdata;
    logic [3:0]  wlanes;

    assign r_oob  = c_ren && ({2'b00, c_raddr[31:2]} >= 32'(DEPTH));
    assign w_oob  = c_wen && ({2'b00, c_waddr[31:2]} >= 32'(DEPTH));
    assign c_err  = r_oob || w_oob;
    assign rword  = mem[c_raddr[AW+1:2]];
    assign rdata  = rword >> {c_raddr[1:0], 3'b000};
    assign wlanes = c_wmask << c_waddr[1:0];
    assign wdata  = c_din << {c_waddr[1:0], 3'b000};
    assign we     = commit && c_wen && !c_err && !rst;

    always_comb begin
        dout_d = dout_q;
        err_d  = err_q;
        if (commit) begin
            err_d  = c_err;
            dout_d = (c_ren && !c_err) ? rdata : 32'h0;
        end else if (state_q == StResp) begin
            err_d  = 1'b0;
            dout_d = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dout_q  <= 32'h0;
            err_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            wmask_q <= 4'h0;
            raddr_q <= 32'h0;
            waddr_q <= 32'h0;
            din_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            if (from_idle && valid) begin
                ren_q   <= ren;
                wen_q   <= wen;
                wmask_q <= wmask[3:0];
                raddr_q <= raddr;
                waddr_q <= waddr;
                din_q   <= din;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wlanes[b]) begin
                    mem[c_waddr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = (state_q == StResp);
    assign dout      = dout_q;
    assign resp_err  = err_q;

endmodule
